// File: rtl/rv32_wb_ram_slave.sv
// Wishbone B4 classic-cycle RAM responder with programmable wait states.
// Byte-lane writes, registered read data, error termination for misses.
module rv32_wb_ram_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [3:0]  BASE_NIBBLE = 4'h2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_M1 =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [25:0] DEPTH_L = 26'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic [31:0] rdat_q, rdat_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          req;
  logic          to_resp;
  logic          mem_we;
  logic [31:0]   c_adr;
  logic [31:0]   c_dat;
  logic [3:0]    c_sel;
  logic          c_we;
  logic          c_ok;
  logic [AW-1:0] c_idx;
  logic          unused_lo;

  // With no wait states the accept edge is also the response edge,
  // so the transfer fields come straight from the bus in IDLE.
  always_comb begin
    req   = wb_cyc_i & wb_stb_i;
    c_adr = (state_q == IDLE) ? wb_adr_i : adr_q;
    c_dat = (state_q == IDLE) ? wb_dat_i : dat_q;
    c_sel = (state_q == IDLE) ? wb_sel_i : sel_q;
    c_we  = (state_q == IDLE) ? wb_we_i  : we_q;
    c_ok  = (c_adr[31:28] == BASE_NIBBLE) &&
            (c_adr[27:2] < DEPTH_L);
    c_idx = c_adr[AW+1:2];
  end

  assign unused_lo = ^c_adr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    to_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          adr_d = wb_adr_i;
          dat_d = wb_dat_i;
          sel_d = wb_sel_i;
          we_d  = wb_we_i;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WS_M1;
          end else begin
            to_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          to_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (to_resp) begin
      state_d = RESP;
      ack_d   = c_ok;
      err_d   = !c_ok;
      if (c_ok && !c_we) rdat_d = mem[c_idx];
    end
    mem_we = to_resp & c_ok & c_we;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      rdat_q  <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (c_sel[b]) mem[c_idx][8*b +: 8] <= c_dat[8*b +: 8];
      end
    end
  end

  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule
